// File: rtl/dbg_ring_link_buffer.sv
// Per-channel debug-ring link buffer: a registered FIFO on each channel, plus an
// output gate that can park the channel at a packet boundary when hold is asserted.
module dbg_ring_link_buffer #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        in_data,
    input  logic [CHANNELS-1:0]                   in_last,
    input  logic [CHANNELS-1:0]                   in_valid,
    output logic [CHANNELS-1:0]                   in_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0]        out_data,
    output logic [CHANNELS-1:0]                   out_last,
    output logic [CHANNELS-1:0]                   out_valid,
    input  logic [CHANNELS-1:0]                   out_ready,
    input  logic [CHANNELS-1:0]                   hold,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CHANNELS-1:0]                   held
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    typedef enum logic {
        OPEN = 1'b0,
        HELD = 1'b1
    } state_e;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH:0] mem_q [DEPTH];
        logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
        logic [OW-1:0]       occ_q, occ_d;
        logic                in_packet_q, in_packet_d;
        state_e              state_q, state_d;
        logic [DATA_WIDTH:0] head;
        logic                rdy, vld, push, pop;

        // Ready and valid come only from flops, so upstream never sees out_ready or hold.
        assign rdy  = occ_q < FULL_OCC;
        assign vld  = (occ_q != '0) && (state_q == OPEN);
        assign push = in_valid[c] & rdy;
        assign pop  = vld & out_ready[c];
        assign head = mem_q[rd_ptr_q];

        assign in_ready[c]                            = rdy;
        assign out_valid[c]                           = vld;
        assign out_data[c*DATA_WIDTH +: DATA_WIDTH]   = head[DATA_WIDTH-1:0];
        assign out_last[c]                            = head[DATA_WIDTH];
        assign occupancy[c*OW +: OW]                  = occ_q;
        assign held[c]                                = (state_q == HELD);

        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        always_comb begin
            wr_ptr_d    = wr_ptr_q;
            rd_ptr_d    = rd_ptr_q;
            occ_d       = occ_q;
            in_packet_d = in_packet_q;
            state_d     = state_q;

            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

            case ({push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase

            if (pop) in_packet_d = ~head[DATA_WIDTH];

            // The hold decision looks at in_packet after this edge's pop, so a closing flit frees it.
            case (state_q)
                OPEN:    if (hold[c] && !in_packet_d) state_d = HELD;
                HELD:    if (!hold[c])                state_d = OPEN;
                default: state_d = OPEN;
            endcase
        end

        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                occ_q       <= '0;
                in_packet_q <= 1'b0;
                state_q     <= OPEN;
            end else begin
                wr_ptr_q    <= wr_ptr_d;
                rd_ptr_q    <= rd_ptr_d;
                occ_q       <= occ_d;
                in_packet_q <= in_packet_d;
                state_q     <= state_d;
            end
        end

        // NOTE: storage is not reset; clearing occupancy is enough to make stale entries invisible.
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= {in_last[c], in_data[c*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

endmodule

// File: tb/tb_dbg_ring_link_buffer.sv
// Directed bench for dbg_ring_link_buffer: stimulus queues expected flits per channel,
// a negedge monitor pops and compares them whenever a channel hands a flit downstream.
module tb_dbg_ring_link_buffer;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int DP = 4;
    localparam int OW = 3;

    logic               clk;
    logic               rst_n;
    logic [CH*DW-1:0]   in_data;
    logic [CH-1:0]      in_last;
    logic [CH-1:0]      in_valid;
    logic [CH-1:0]      in_ready;
    logic [CH*DW-1:0]   out_data;
    logic [CH-1:0]      out_last;
    logic [CH-1:0]      out_valid;
    logic [CH-1:0]      out_ready;
    logic [CH-1:0]      hold;
    logic [CH*OW-1:0]   occupancy;
    logic [CH-1:0]      held;

    int checks = 0;
    int errors = 0;
    int rx_cnt1 = 0;

    logic [DW:0] exp_q0 [$];
    logic [DW:0] exp_q1 [$];

    dbg_ring_link_buffer #(.CHANNELS(CH), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hold      (hold),
        .occupancy (occupancy),
        .held      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int ch, input logic v, input logic [DW-1:0] d, input logic l);
        in_valid[ch]          = v;
        in_data[ch*DW +: DW]  = d;
        in_last[ch]           = l;
    endtask

    // Offer a flit the bench expects the buffer to accept, and queue it for the monitor.
    task automatic offer(input int ch, input logic [DW-1:0] d, input logic l);
        set_in(ch, 1'b1, d, l);
        if (ch == 0) exp_q0.push_back({l, d});
        else         exp_q1.push_back({l, d});
    endtask

    // Monitor: a flit is handed over when valid & ready are both high across the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid[0] && out_ready[0]) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_ch0_unexpected got %h expected none", {out_last[0], out_data[DW-1:0]});
            end else begin
                check("rx_ch0", 32'({out_last[0], out_data[DW-1:0]}), 32'(exp_q0.pop_front()));
            end
        end
        if (rst_n && out_valid[1] && out_ready[1]) begin
            rx_cnt1++;
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_ch1_unexpected got %h expected none", {out_last[1], out_data[2*DW-1:DW]});
            end else begin
                check("rx_ch1", 32'({out_last[1], out_data[2*DW-1:DW]}), 32'(exp_q1.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; in_data = '0; in_last = '0; in_valid = '0; out_ready = '0; hold = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_occ",       32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'b11);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_held",      32'(held),      32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Pass-through on ch0 with ch1 idle.
        out_ready = 2'b11;
        offer(0, 16'h1234, 1'b1);
        @(negedge clk);
        check("pt_no_fallthrough", 32'(out_valid), 32'b00);
        tick();
        set_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("pt_valid", 32'(out_valid), 32'b01);
        check("pt_occ",   32'(occupancy), 32'd1);
        tick();
        @(negedge clk);
        check("pt_drained", 32'(occupancy), 32'd0);
        tick();

        // Fill ch0 to DEPTH, refuse a fifth flit, then drain.
        out_ready = 2'b00;
        for (int i = 0; i < DP; i++) begin
            offer(0, 16'hA000 + 16'(i), 1'b1);
            @(negedge clk);
            check("fill_rdy", 32'(in_ready[0]), 32'd1);
            tick();
        end
        set_in(0, 1'b1, 16'hDEAD, 1'b1);
        @(negedge clk);
        check("full_occ",   32'(occupancy[OW-1:0]), 32'd4);
        check("full_rdy",   32'(in_ready[0]),       32'd0);
        check("full_valid", 32'(out_valid[0]),      32'd1);
        tick();
        set_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("full_refused", 32'(occupancy[OW-1:0]), 32'd4);
        tick();
        out_ready[0] = 1'b1;
        repeat (DP) tick();
        @(negedge clk);
        check("drain_occ",   32'(occupancy[OW-1:0]), 32'd0);
        check("drain_valid", 32'(out_valid[0]),      32'd0);
        tick();

        // Simultaneous push and pop at occupancy 2.
        out_ready[0] = 1'b0;
        offer(0, 16'hB000, 1'b1); tick();
        offer(0, 16'hB001, 1'b1); tick();
        offer(0, 16'hB002, 1'b1);
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("sim_occ_pre", 32'(occupancy[OW-1:0]), 32'd2);
        tick();
        offer(0, 16'hB003, 1'b1);
        @(negedge clk);
        check("sim_occ_1", 32'(occupancy[OW-1:0]), 32'd2);
        tick();
        set_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("sim_occ_2", 32'(occupancy[OW-1:0]), 32'd2);
        tick(); tick();
        @(negedge clk);
        check("sim_drained", 32'(occupancy[OW-1:0]), 32'd0);
        tick();

        // Hold asserted after the first flit of a three-flit packet has gone.
        out_ready[0] = 1'b0;
        offer(0, 16'hC000, 1'b0); tick();
        offer(0, 16'hC001, 1'b0); tick();
        offer(0, 16'hC002, 1'b1); tick();
        offer(0, 16'hD000, 1'b1); tick();
        set_in(0, 1'b0, '0, 1'b0);
        out_ready[0] = 1'b1;
        tick();
        hold[0] = 1'b1;
        @(negedge clk);
        check("hold_mid_held",  32'(held[0]),      32'd0);
        check("hold_mid_valid", 32'(out_valid[0]), 32'd1);
        tick();
        @(negedge clk);
        check("hold_last_held",  32'(held[0]),      32'd0);
        check("hold_last_valid", 32'(out_valid[0]), 32'd1);
        tick();
        @(negedge clk);
        check("hold_held",  32'(held[0]),            32'd1);
        check("hold_stall", 32'(out_valid[0]),       32'd0);
        check("hold_occ",   32'(occupancy[OW-1:0]),  32'd1);
        tick();
        offer(0, 16'hE000, 1'b1);
        @(negedge clk);
        check("held_rdy", 32'(in_ready[0]), 32'd1);
        tick();
        set_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("held_accept_occ", 32'(occupancy[OW-1:0]), 32'd2);
        check("held_still",      32'(held[0]),           32'd1);
        tick();
        hold[0] = 1'b0;
        @(negedge clk);
        check("release_pre_held",  32'(held[0]),      32'd1);
        check("release_pre_valid", 32'(out_valid[0]), 32'd0);
        tick();
        @(negedge clk);
        check("release_held",  32'(held[0]),      32'd0);
        check("release_valid", 32'(out_valid[0]), 32'd1);
        tick(); tick();
        @(negedge clk);
        check("release_drained", 32'(occupancy[OW-1:0]), 32'd0);
        tick();

        // Reset in the middle of a packet with three flits still buffered.
        out_ready[0] = 1'b0;
        for (int i = 0; i < DP; i++) begin
            offer(0, 16'hF000 + 16'(i), 1'b0);
            tick();
        end
        set_in(0, 1'b0, '0, 1'b0);
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        hold[0] = 1'b1;
        @(negedge clk);
        check("pre_rst_occ",  32'(occupancy[OW-1:0]), 32'd3);
        check("pre_rst_held", 32'(held[0]),           32'd0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        exp_q0.delete();
        check("rstmid_occ",      32'(occupancy), 32'd0);
        check("rstmid_valid",    32'(out_valid), 32'd0);
        check("rstmid_held",     32'(held),      32'd0);
        check("rstmid_in_ready", 32'(in_ready),  32'b11);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_open", 32'(held[0]), 32'd0);
        tick();
        @(negedge clk);
        check("post_rst_pkt_clear", 32'(held[0]), 32'd1);
        tick();
        hold[0] = 1'b0;
        out_ready[0] = 1'b1;
        offer(0, 16'h6000, 1'b1);
        tick();
        set_in(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("post_rst_held",  32'(held[0]),      32'd0);
        check("post_rst_valid", 32'(out_valid[0]), 32'd1);
        tick();

        // Back-to-back stream on ch1, long enough to wrap the pointers several times.
        out_ready[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(1, 16'h5100 + 16'(i), (i % 5) == 4);
            @(negedge clk);
            check("wrap_rdy", 32'(in_ready[1]), 32'd1);
            tick();
        end
        set_in(1, 1'b0, '0, 1'b0);
        tick(); tick();
        @(negedge clk);
        check("wrap_occ", 32'(occupancy[2*OW-1:OW]), 32'd0);
        check("wrap_cnt", 32'(rx_cnt1),              32'd20);
        check("end_q0_empty", 32'(exp_q0.size()), 32'd0);
        check("end_q1_empty", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_ring_link_buffer.md
DBG_RING_LINK_BUFFER -- requirements
Module: dbg_ring_link_buffer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent debug-ring channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: flit payload width per channel.
REQ-003 SHALL have parameter DEPTH, default 4: FIFO entries per channel; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, CHANNELS*DATA_WIDTH: upstream payload; channel c occupies bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH].
REQ-007 SHALL have port in_last, input, CHANNELS: upstream end-of-packet flag per channel.
REQ-008 SHALL have port in_valid, input, CHANNELS: upstream flit valid per channel.
REQ-009 SHALL have port in_ready, output, CHANNELS: buffer can accept a flit on that channel.
REQ-010 SHALL have port out_data, output, CHANNELS*DATA_WIDTH: downstream payload, same packing as in_data.
REQ-011 SHALL have port out_last, output, CHANNELS: downstream end-of-packet flag.
REQ-012 SHALL have port out_valid, output, CHANNELS: downstream flit valid.
REQ-013 SHALL have port out_ready, input, CHANNELS: downstream accepts a flit.
REQ-014 SHALL have port hold, input, CHANNELS: request to stop forwarding on that channel at the next packet boundary.
REQ-015 SHALL have port occupancy, output, CHANNELS*$clog2(DEPTH+1): per-channel entry count, same packing scheme.
REQ-016 SHALL have port held, output, CHANNELS: that channel is currently stopped at a packet boundary.

Function
REQ-017 SHALL implement one independent FIFO of DEPTH entries, each {last, data}, per channel; no cross-channel interaction.
REQ-018 SHALL push on in_valid & in_ready and pop on out_valid & out_ready, both at the clock edge.
REQ-019 SHALL drive in_ready = (occupancy < DEPTH), from registered state only; no combinational path from out_ready or hold to in_ready.
REQ-020 SHALL present a pushed flit at the outputs no earlier than the cycle after the push (one-cycle minimum latency, no fall-through).
REQ-021 SHALL update occupancy by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-022 SHALL allow a simultaneous push and pop whenever 0 < occupancy < DEPTH; occupancy = 0 admits push only and occupancy = DEPTH admits pop only.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL implement a per-channel output state machine with states OPEN and HELD, entered OPEN at reset.
REQ-025 SHALL drive out_valid = (occupancy > 0) & (state == OPEN), and out_data/out_last from the head entry.
REQ-026 SHALL track a per-channel in_packet flag: set on a pop with last = 0, cleared on a pop with last = 1.
REQ-027 SHALL transition OPEN -> HELD at an edge where hold = 1 and, after that edge's pop, in_packet = 0; a packet in progress completes before the channel holds.
REQ-028 SHALL transition HELD -> OPEN at an edge where hold = 0.
REQ-029 SHALL drive held = (state == HELD).
REQ-030 SHALL keep accepting upstream flits while HELD until the FIFO is full.
REQ-031 SHALL require out_data/out_last to stay stable while out_valid = 1 and out_ready = 0.

Reset
REQ-032 SHALL, while rst_n = 0, asynchronously clear all pointers, occupancy, and in_packet flags, and set every channel to OPEN.
REQ-033 SHALL output during reset: out_valid = 0, held = 0, occupancy = 0, in_ready = all ones; out_data/out_last are don't-care.
REQ-034 SHALL discard any buffered flits and partial packets when reset is asserted mid-operation.

Verification
REQ-035 Pass-through (CHANNELS = 2, DEPTH = 4): push 0x1234 on ch0 with out_ready = 1 -> out_valid[0] = 1 with 0x1234 exactly one cycle later; ch1 unaffected.
REQ-036 Full/empty: out_ready = 0, push 4 flits on ch0 -> occupancy = 4, in_ready[0] = 0; a 5th offer is not accepted. Then pop 4 -> occupancy = 0, out_valid[0] = 0.
REQ-037 Simultaneous push/pop at occupancy = 2 -> occupancy stays 2 and data order is preserved.
REQ-038 Hold mid-packet: 3-flit packet with flit 1 already popped, assert hold -> flits 2 and 3 still delivered; held = 1 the cycle after last pops; next packet's head stalled with out_valid = 0. Deassert hold -> it resumes.
REQ-039 Reset mid-packet: rst_n low with occupancy = 3 -> occupancy = 0, out_valid = 0, state OPEN immediately, without waiting for a clock edge.
REQ-040 Wrap-around: 20 consecutive flits on ch1 at full throughput -> received in order with no loss or duplication.
